// File: rtl/mem_access_ctrl.sv
// Bus-access controller between the load/store aligner and the external
// memory bus. It runs one valid/ready bus cycle per request, rejects
// misaligned accesses without touching the bus, and aborts stalled cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req_valid; the only state that samples a request
// BUS   | bus_valid asserted, address/strobes/data held until completion
// RESP  | req_ready (and resp_error) presented for exactly one cycle
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_wstrobe,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        bus_valid,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_wstrobe,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Zero disables the abort; the last wait count is only meaningful otherwise.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        op_write;
  logic        misaligned;
  logic        timeout_hit;

  // Half-words need bit 0 clear; words (and the size-3 alias) need both bits clear.
  always_comb begin
    misaligned = 1'b0;
    if (req_size == 2'd1)
      misaligned = req_address[0];
    else if (req_size[1])
      misaligned = |req_address[1:0];
  end

  // Abort fires in the wait cycle whose count (before increment) hits the limit.
  always_comb begin
    timeout_hit = TO_EN && (wait_cnt == TO_LAST);
  end

  // Sequencer: state, wait counter and every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 16'd0;
      op_write    <= 1'b0;
      req_ready   <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_error  <= 1'b0;
      bus_valid   <= 1'b0;
      bus_address <= 32'd0;
      bus_wstrobe <= 4'd0;
      bus_wdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready  <= 1'b0;
          resp_error <= 1'b0;
          if (req_valid) begin
            if (misaligned) begin
              req_ready  <= 1'b1;
              resp_error <= 1'b1;
              state      <= RESP;
            end else begin
              bus_address <= {req_address[31:2], 2'b00};
              bus_wdata   <= req_wdata;
              bus_wstrobe <= req_write ? req_wstrobe : 4'd0;
              op_write    <= req_write;
              bus_valid   <= 1'b1;
              wait_cnt    <= 16'd0;
              state       <= BUS;
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            if (!op_write)
              resp_rdata <= bus_rdata;
            bus_valid  <= 1'b0;
            req_ready  <= 1'b1;
            resp_error <= 1'b0;
            state      <= RESP;
          end else if (timeout_hit) begin
            bus_valid  <= 1'b0;
            req_ready  <= 1'b1;
            resp_error <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          req_ready  <= 1'b0;
          resp_error <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus_valid  <= 1'b0;
          req_ready  <= 1'b0;
          resp_error <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 4-cycle bus timeout.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_address;
  logic [3:0]  req_wstrobe;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        bus_valid;
  logic [31:0] bus_address;
  logic [3:0]  bus_wstrobe;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int n_cmp = 0;
  int n_err = 0;
  int bv_rises = 0;
  logic bv_prev = 1'b0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_address(req_address), .req_wstrobe(req_wstrobe), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrobe(bus_wstrobe),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  // Count bus_valid rising edges to prove transactions are separated by a low cycle.
  always @(negedge clk) begin
    if (bus_valid && !bv_prev) bv_rises++;
    bv_prev <= bus_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; waits < 0 means the bus never answers.
  task automatic xfer(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd, input int waits,
                      input logic [31:0] rd, output int lat, output int vcyc,
                      output logic [31:0] b_addr, output logic [3:0] b_strb,
                      output logic [31:0] b_wd, output logic stable);
    bit done = 0;
    lat = 0; vcyc = 0; stable = 1'b1;
    b_addr = 32'hX; b_strb = 4'hX; b_wd = 32'hX;
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_address = addr; req_wstrobe = strb; req_wdata = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      lat++;
      if (req_ready) begin
        done = 1;
      end else if (bus_valid) begin
        vcyc++;
        if (vcyc == 1) begin
          b_addr = bus_address; b_strb = bus_wstrobe; b_wd = bus_wdata;
        end else if (bus_address !== b_addr || bus_wstrobe !== b_strb || bus_wdata !== b_wd) begin
          stable = 1'b0;
        end
        if (waits >= 0 && vcyc == waits + 1) begin
          bus_ready = 1'b1; bus_rdata = rd;
        end else begin
          bus_ready = 1'b0; bus_rdata = 32'h0BAD_0BAD;
        end
      end else begin
        bus_ready = 1'b0;
      end
    end
    if (!done) check("xfer_completes", 32'd0, 32'd1);
    req_valid = 1'b0;
    bus_ready = 1'b0;
  endtask

  int lat, lat2, vcyc, vcyc2, rises0;
  logic [31:0] ba, bw;
  logic [3:0]  bs;
  logic        st;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_address = 32'd0; req_wstrobe = 4'd0; req_wdata = 32'd0;
    bus_rdata = 32'd0; bus_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    reset_n = 1'b1;
    tick();

    // Aligned load: low address bits cleared, strobes forced off for loads.
    xfer(1'b0, 2'd0, 32'h0000_1006, 4'hF, 32'h5555_AAAA, 0, 32'hDEAD_BEEF,
         lat, vcyc, ba, bs, bw, st);
    check("load_lat", lat, 32'd2);
    check("load_vcyc", vcyc, 32'd1);
    check("load_bus_addr", ba, 32'h0000_1004);
    check("load_bus_strb", {28'd0, bs}, 32'd0);
    check("load_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("load_err", {31'd0, resp_error}, 32'd0);
    tick();
    check("load_ready_drops", {31'd0, req_ready}, 32'd0);

    // Half store with three wait states; rdata keeps the previous load value.
    xfer(1'b1, 2'd1, 32'h0000_0020, 4'b0011, 32'h1234_1234, 3, 32'hFFFF_0000,
         lat, vcyc, ba, bs, bw, st);
    check("st_lat", lat, 32'd5);
    check("st_vcyc", vcyc, 32'd4);
    check("st_stable", {31'd0, st}, 32'd1);
    check("st_bus_addr", ba, 32'h0000_0020);
    check("st_bus_strb", {28'd0, bs}, 32'h3);
    check("st_bus_wdata", bw, 32'h1234_1234);
    check("st_err", {31'd0, resp_error}, 32'd0);
    check("st_rdata_held", resp_rdata, 32'hDEAD_BEEF);
    tick();

    // Misaligned word load and half store: no bus cycle, error one cycle later.
    rises0 = bv_rises;
    xfer(1'b0, 2'd2, 32'h0000_0002, 4'h0, 32'h0, 0, 32'h1111_1111,
         lat, vcyc, ba, bs, bw, st);
    check("mis_w_lat", lat, 32'd1);
    check("mis_w_err", {31'd0, resp_error}, 32'd1);
    check("mis_w_rdata", resp_rdata, 32'hDEAD_BEEF);
    tick();
    check("mis_w_err_clr", {31'd0, resp_error}, 32'd0);
    xfer(1'b1, 2'd1, 32'h0000_0001, 4'b0110, 32'h0, 0, 32'h1111_1111,
         lat, vcyc, ba, bs, bw, st);
    check("mis_h_lat", lat, 32'd1);
    check("mis_h_err", {31'd0, resp_error}, 32'd1);
    check("mis_no_bus", bv_rises - rises0, 32'd0);
    tick();

    // Size 3 behaves as a word for alignment.
    xfer(1'b0, 2'd3, 32'h0000_0043, 4'h0, 32'h0, 0, 32'h0,
         lat, vcyc, ba, bs, bw, st);
    check("size3_err", {31'd0, resp_error}, 32'd1);
    tick();

    // Timeout: bus never answers, abort after four bus_valid cycles.
    xfer(1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0, -1, 32'h0,
         lat, vcyc, ba, bs, bw, st);
    check("to_vcyc", vcyc, 32'd4);
    check("to_lat", lat, 32'd5);
    check("to_err", {31'd0, resp_error}, 32'd1);
    check("to_rdata_held", resp_rdata, 32'hDEAD_BEEF);
    tick();

    // bus_ready in the fourth cycle beats the timeout.
    xfer(1'b0, 2'd2, 32'h0000_0104, 4'h0, 32'h0, 3, 32'hCAFE_F00D,
         lat, vcyc, ba, bs, bw, st);
    check("to_edge_vcyc", vcyc, 32'd4);
    check("to_edge_err", {31'd0, resp_error}, 32'd0);
    check("to_edge_rdata", resp_rdata, 32'hCAFE_F00D);
    tick();

    // Store with empty strobes still runs a bus cycle.
    xfer(1'b1, 2'd2, 32'h0000_0200, 4'h0, 32'hA5A5_A5A5, 0, 32'h0,
         lat, vcyc, ba, bs, bw, st);
    check("st0_vcyc", vcyc, 32'd1);
    check("st0_strb", {28'd0, bs}, 32'd0);
    tick();

    // bus_ready while idle is ignored.
    bus_ready = 1'b1;
    tick(); tick();
    check("idle_ready_ignored", {31'd0, req_ready}, 32'd0);
    bus_ready = 1'b0;
    tick();

    // Back-to-back loads: second request sampled in the IDLE cycle after RESP.
    rises0 = bv_rises;
    xfer(1'b0, 2'd2, 32'h0000_0300, 4'h0, 32'h0, 0, 32'h0000_0001,
         lat, vcyc, ba, bs, bw, st);
    xfer(1'b0, 2'd2, 32'h0000_0304, 4'h0, 32'h0, 0, 32'h0000_0002,
         lat2, vcyc2, ba, bs, bw, st);
    check("b2b_lat1", lat, 32'd2);
    check("b2b_lat2", lat2, 32'd3);
    check("b2b_rdata", resp_rdata, 32'h0000_0002);
    tick();
    check("b2b_bv_rises", bv_rises - rises0, 32'd2);

    // Reset in the middle of a bus cycle abandons it.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
    req_address = 32'h0000_0400; bus_ready = 1'b0;
    tick(); tick();
    check("mid_bus_valid", {31'd0, bus_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_bv_drop", {31'd0, bus_valid}, 32'd0);
    lat = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (req_ready) lat++;
    end
    check("mid_rst_no_ready", lat, 32'd0);
    req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    check("post_rst_rdata", resp_rdata, 32'd0);
    check("post_rst_addr", bus_address, 32'd0);
    check("post_rst_flags", {28'd0, req_ready, resp_error, bus_valid, |bus_wstrobe}, 32'd0);
    check("post_rst_wdata", bus_wdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
